program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a count header, assembles big-endian words
// into instruction memory, verifies an XOR checksum and releases the processor.
module program_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        start_up,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;

    state_t      state;
    logic [7:0]  count_hi;
    logic [7:0]  csum;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_acc;
    logic        xfer;
    logic        can_start;
    logic [15:0] count;
    logic [15:0] idx_next;

    assign byte_ready = (state == HDR_HI) || (state == HDR_LO) ||
                        (state == DATA)   || (state == CSUM);
    assign xfer      = byte_valid && byte_ready;
    assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
    assign count     = {count_hi, byte_data};
    assign idx_next  = word_idx + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count_hi   <= 8'h00;
            csum       <= 8'h00;
            n_words    <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            word_acc   <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            start_up   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (load_start && can_start) begin
                // DONE/ERR have byte_ready low, so a coincident byte is never taken here
                state    <= HDR_HI;
                csum     <= 8'h00;
                word_idx <= 16'd0;
                byte_cnt <= 2'd0;
                done     <= 1'b0;
                error    <= 1'b0;
                start_up <= 1'b1;
            end else if (xfer) begin
                case (state)
                    HDR_HI: begin
                        count_hi <= byte_data;
                        csum     <= csum ^ byte_data;
                        state    <= HDR_LO;
                    end
                    HDR_LO: begin
                        csum    <= csum ^ byte_data;
                        n_words <= count;
                        if (count == 16'd0 || 32'(count) > MAX_WORDS) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        csum     <= csum ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_acc <= {word_acc[15:0], byte_data};
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {word_acc, byte_data};
                            imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx   <= idx_next;
                            if (idx_next == n_words) state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (byte_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            start_up <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule
